// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style command sequencer: FSM state
// encodings, ICW/OCW bit positions and the OCW2 command codes.
package pic_pkg;

  // FSM state encodings, kept as plain constants so the debug port value
  // matches the legacy numbering exactly.
  localparam logic [2:0] WAIT_ICW1 = 3'd0;
  localparam logic [2:0] WAIT_ICW2 = 3'd1;
  localparam logic [2:0] WAIT_ICW3 = 3'd2;
  localparam logic [2:0] WAIT_ICW4 = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  // Bit positions in the written byte.
  localparam int D4_ICW1  = 4;
  localparam int D3_OCW3  = 3;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;
  localparam int RR   = 1;
  localparam int RIS  = 0;
  localparam int P    = 2;
  localparam int ESMM = 6;
  localparam int SMM  = 5;

  // OCW2 R/SL/EOI command codes.
  typedef enum logic [2:0] {
    ROT_AEOI_CLR = 3'b000,
    NS_EOI       = 3'b001,
    OCW2_NOP     = 3'b010,
    SP_EOI       = 3'b011,
    ROT_AEOI_SET = 3'b100,
    ROT_NS_EOI   = 3'b101,
    SET_PRIO     = 3'b110,
    ROT_SP_EOI   = 3'b111
  } ocw2_cmd_t;

endpackage

// File: rtl/pic_cmd_sequencer.sv
// Decodes CPU write bytes into 8259 ICW1-ICW4 / OCW1-OCW3 state, tracks the
// initialization sequence and emits one-cycle command pulses downstream.
// Optional macro PIC_SPECIAL_MASK_EN adds the OCW3 special-mask-mode flop.
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] IMR_INIT    = 8'h00,
  parameter logic [4:0] VECTOR_INIT = 5'b00000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_stb,
  input  logic       a0,
  input  logic [7:0] int_data,
  output logic       init_done,
  output logic       icw1_pulse,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       upm,
  output logic       aeoi,
  output logic       ms_sel,
  output logic       buf_mode,
  output logic       sfnm,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr,
  output logic       poll_pulse,
  output logic       smm,
  output logic [2:0] fsm_state
);

  logic is_icw1;
  logic is_ocw2;
  logic is_ocw3;
  logic is_a0;

  // Classify the current strobe; ICW1 wins over every other decode.
  always_comb begin
    is_icw1 = wr_stb & ~a0 & int_data[D4_ICW1];
    is_ocw2 = wr_stb & ~a0 & ~int_data[D4_ICW1] & ~int_data[D3_OCW3];
    is_ocw3 = wr_stb & ~a0 & ~int_data[D4_ICW1] &  int_data[D3_OCW3];
    is_a0   = wr_stb & a0;
  end

  // Init-sequence FSM, configuration registers and command pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state   <= WAIT_ICW1;
      init_done   <= 1'b0;
      icw1_pulse  <= 1'b0;
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      ic4         <= 1'b0;
      vector_base <= VECTOR_INIT;
      cascade_cfg <= 8'h00;
      upm         <= 1'b0;
      aeoi        <= 1'b0;
      ms_sel      <= 1'b0;
      buf_mode    <= 1'b0;
      sfnm        <= 1'b0;
      imr         <= IMR_INIT;
      ocw2_valid  <= 1'b0;
      ocw2_cmd    <= 3'b000;
      ocw2_level  <= 3'b000;
      read_isr    <= 1'b0;
      poll_pulse  <= 1'b0;
    end else begin
      icw1_pulse <= 1'b0;
      ocw2_valid <= 1'b0;
      poll_pulse <= 1'b0;
      if (is_icw1) begin
        ltim       <= int_data[ICW1_LTIM];
        sngl       <= int_data[ICW1_SNGL];
        ic4        <= int_data[ICW1_IC4];
        imr        <= IMR_INIT;
        init_done  <= 1'b0;
        read_isr   <= 1'b0;
        icw1_pulse <= 1'b1;
        fsm_state  <= WAIT_ICW2;
        if (!int_data[ICW1_IC4]) begin
          upm      <= 1'b0;
          aeoi     <= 1'b0;
          ms_sel   <= 1'b0;
          buf_mode <= 1'b0;
          sfnm     <= 1'b0;
        end
      end else begin
        case (fsm_state)
          WAIT_ICW2: begin
            if (is_a0) begin
              vector_base <= int_data[7:3];
              if (!sngl) begin
                fsm_state <= WAIT_ICW3;
              end else if (ic4) begin
                fsm_state <= WAIT_ICW4;
              end else begin
                fsm_state <= READY;
                init_done <= 1'b1;
              end
            end
          end
          WAIT_ICW3: begin
            if (is_a0) begin
              cascade_cfg <= int_data;
              if (ic4) begin
                fsm_state <= WAIT_ICW4;
              end else begin
                fsm_state <= READY;
                init_done <= 1'b1;
              end
            end
          end
          WAIT_ICW4: begin
            if (is_a0) begin
              upm       <= int_data[0];
              aeoi      <= int_data[1];
              ms_sel    <= int_data[2];
              buf_mode  <= int_data[3];
              sfnm      <= int_data[4];
              fsm_state <= READY;
              init_done <= 1'b1;
            end
          end
          READY: begin
            if (is_a0) begin
              imr <= int_data;
            end else if (is_ocw2) begin
              ocw2_valid <= 1'b1;
              ocw2_cmd   <= int_data[7:5];
              ocw2_level <= int_data[2:0];
            end else if (is_ocw3) begin
              if (int_data[RR]) begin
                read_isr <= int_data[RIS];
              end
              if (int_data[P]) begin
                poll_pulse <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef PIC_SPECIAL_MASK_EN
  // Special mask mode: set/cleared by OCW3 when ESMM is high, cleared by ICW1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smm <= 1'b0;
    end else if (is_icw1) begin
      smm <= 1'b0;
    end else if (fsm_state == READY && is_ocw3 && int_data[ESMM]) begin
      smm <= int_data[SMM];
    end
  end
`else
  assign smm = 1'b0;
`endif

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed self-checking bench for pic_cmd_sequencer.
module tb_pic_cmd_sequencer;
  import pic_pkg::*;

  logic       clk;
  logic       reset;
  logic       wr_stb;
  logic       a0;
  logic [7:0] int_data;
  logic       init_done, icw1_pulse, ltim, sngl, ic4;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg;
  logic       upm, aeoi, ms_sel, buf_mode, sfnm;
  logic [7:0] imr;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd, ocw2_level;
  logic       read_isr, poll_pulse, smm;
  logic [2:0] fsm_state;

  int vectors;
  int miscompares;
  logic smm_exp;

  pic_cmd_sequencer dut (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .a0(a0), .int_data(int_data),
    .init_done(init_done), .icw1_pulse(icw1_pulse), .ltim(ltim), .sngl(sngl),
    .ic4(ic4), .vector_base(vector_base), .cascade_cfg(cascade_cfg),
    .upm(upm), .aeoi(aeoi), .ms_sel(ms_sel), .buf_mode(buf_mode),
    .sfnm(sfnm), .imr(imr), .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd),
    .ocw2_level(ocw2_level), .read_isr(read_isr), .poll_pulse(poll_pulse),
    .smm(smm), .fsm_state(fsm_state)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write strobe for a single cycle; returns 1 time unit after the edge.
  task automatic applyStimulus(input logic a, input logic [7:0] d);
    wr_stb   = 1'b1;
    a0       = a;
    int_data = d;
    @(posedge clk);
    #1;
    wr_stb   = 1'b0;
    a0       = 1'b0;
    int_data = 8'h00;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one idle cycle, landing 1 time unit after the edge.
  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    wr_stb      = 1'b0;
    a0          = 1'b0;
    int_data    = 8'h00;
    #12;
    checkOutput("rst_state",  {5'd0, fsm_state}, 8'h00);
    checkOutput("rst_done",   {7'd0, init_done}, 8'h00);
    checkOutput("rst_imr",    imr, 8'h00);
    checkOutput("rst_vec",    {3'd0, vector_base}, 8'h00);
    checkOutput("rst_pulses", {5'd0, icw1_pulse, ocw2_valid, poll_pulse}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    idleCycle();

    // a0=1 write before ICW1 is ignored
    applyStimulus(1'b1, 8'hFF);
    checkOutput("pre_icw1_imr",   imr, 8'h00);
    checkOutput("pre_icw1_state", {5'd0, fsm_state}, 8'h00);

    // Full cascade sequence with ICW4
    applyStimulus(1'b0, 8'h11);
    checkOutput("icw1_state", {5'd0, fsm_state}, 8'h01);
    checkOutput("icw1_pulse", {7'd0, icw1_pulse}, 8'h01);
    checkOutput("icw1_bits",  {5'd0, ltim, sngl, ic4}, 8'h01);
    idleCycle();
    checkOutput("icw1_pulse_end", {7'd0, icw1_pulse}, 8'h00);
    // OCW2-looking write during init is ignored
    applyStimulus(1'b0, 8'h20);
    checkOutput("init_ocw2_ign", {7'd0, ocw2_valid}, 8'h00);
    checkOutput("init_ocw2_st",  {5'd0, fsm_state}, 8'h01);
    applyStimulus(1'b1, 8'h20);
    checkOutput("icw2_vec",   {3'd0, vector_base}, 8'h04);
    checkOutput("icw2_state", {5'd0, fsm_state}, 8'h02);
    applyStimulus(1'b1, 8'h04);
    checkOutput("icw3_cas",   cascade_cfg, 8'h04);
    checkOutput("icw3_state", {5'd0, fsm_state}, 8'h03);
    checkOutput("icw3_done",  {7'd0, init_done}, 8'h00);
    applyStimulus(1'b1, 8'h01);
    checkOutput("icw4_state", {5'd0, fsm_state}, 8'h04);
    checkOutput("icw4_done",  {7'd0, init_done}, 8'h01);
    checkOutput("icw4_upm",   {7'd0, upm}, 8'h01);

    // Single mode: ICW3 skipped
    applyStimulus(1'b0, 8'h13);
    checkOutput("sngl_icw1_done", {7'd0, init_done}, 8'h00);
    applyStimulus(1'b1, 8'h08);
    checkOutput("sngl_icw2_state", {5'd0, fsm_state}, 8'h03);
    checkOutput("sngl_icw2_vec",   {3'd0, vector_base}, 8'h01);
    applyStimulus(1'b1, 8'h03);
    checkOutput("sngl_icw4_bits", {6'd0, aeoi, upm}, 8'h03);
    // Single mode without ICW4: READY right after ICW2, ICW4 bits cleared
    applyStimulus(1'b0, 8'h12);
    checkOutput("noic4_clear", {6'd0, aeoi, upm}, 8'h00);
    applyStimulus(1'b1, 8'h40);
    checkOutput("noic4_state", {5'd0, fsm_state}, 8'h04);
    checkOutput("noic4_done",  {7'd0, init_done}, 8'h01);
    checkOutput("noic4_vec",   {3'd0, vector_base}, 8'h08);
    checkOutput("cas_held",    cascade_cfg, 8'h04);

    // READY-state operations
    applyStimulus(1'b1, 8'hA5);
    checkOutput("ocw1_imr", imr, 8'hA5);
    applyStimulus(1'b0, 8'h20);
    checkOutput("ocw2_valid", {7'd0, ocw2_valid}, 8'h01);
    checkOutput("ocw2_cmd",   {5'd0, ocw2_cmd}, {5'd0, NS_EOI});
    checkOutput("ocw2_level", {5'd0, ocw2_level}, 8'h00);
    idleCycle();
    checkOutput("ocw2_valid_end", {7'd0, ocw2_valid}, 8'h00);
    checkOutput("ocw2_cmd_held",  {5'd0, ocw2_cmd}, 8'h01);
    applyStimulus(1'b0, 8'h65);
    checkOutput("ocw2_sp_cmd",   {5'd0, ocw2_cmd}, {5'd0, SP_EOI});
    checkOutput("ocw2_sp_level", {5'd0, ocw2_level}, 8'h05);
    applyStimulus(1'b0, 8'h0B);
    checkOutput("ocw3_ris",     {7'd0, read_isr}, 8'h01);
    checkOutput("ocw3_no_poll", {7'd0, poll_pulse}, 8'h00);
    applyStimulus(1'b0, 8'h0C);
    checkOutput("ocw3_poll",     {7'd0, poll_pulse}, 8'h01);
    checkOutput("ocw3_ris_held", {7'd0, read_isr}, 8'h01);
    idleCycle();
    checkOutput("ocw3_poll_end", {7'd0, poll_pulse}, 8'h00);
    applyStimulus(1'b0, 8'h0A);
    checkOutput("ocw3_irr", {7'd0, read_isr}, 8'h00);
    checkOutput("ready_imr_held", imr, 8'hA5);

    // Special mask mode
`ifdef PIC_SPECIAL_MASK_EN
    smm_exp = 1'b1;
`else
    smm_exp = 1'b0;
`endif
    applyStimulus(1'b0, 8'h68);
    checkOutput("smm_set",  {7'd0, smm}, {7'd0, smm_exp});
    applyStimulus(1'b0, 8'h28);
    checkOutput("smm_keep", {7'd0, smm}, {7'd0, smm_exp});
    applyStimulus(1'b0, 8'h48);
    checkOutput("smm_clr",  {7'd0, smm}, 8'h00);

    // ICW1 restarts a sequence midway
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b1, 8'h30);
    checkOutput("restart_mid_state", {5'd0, fsm_state}, 8'h02);
    applyStimulus(1'b0, 8'h11);
    checkOutput("restart_state", {5'd0, fsm_state}, 8'h01);
    checkOutput("restart_imr",   imr, 8'h00);
    checkOutput("restart_done",  {7'd0, init_done}, 8'h00);
    checkOutput("restart_vec",   {3'd0, vector_base}, 8'h06);

    // Asynchronous reset between strobes, checked before any clock edge
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_state", {5'd0, fsm_state}, 8'h00);
    checkOutput("async_vec",   {3'd0, vector_base}, 8'h00);
    checkOutput("async_cas",   cascade_cfg, 8'h00);
    checkOutput("async_ltim",  {5'd0, ltim, sngl, ic4}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    idleCycle();
    checkOutput("post_rst_state", {5'd0, fsm_state}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pic_cmd_sequencer.md
Name: pic_cmd_sequencer

Overview:
Consumes CPU write bytes that the data buffer drives onto the internal data bus, and decodes them into 8259 ICW1–ICW4 and OCW1–OCW3 state.
Tracks the initialization sequence with an FSM and holds all configuration registers.
Emits single-cycle command pulses to the priority resolver and interrupt mask logic downstream.
Sits directly downstream of the data buffer / read-write control.

Parameters:
IMR_INIT, 8'h00, IMR value loaded on reset and on every ICW1.
VECTOR_INIT, 5'b00000, vector_base value after reset (ICW2 not yet written).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
wr_stb  input  1  single-cycle write strobe, synchronous to clk, from read/write control
a0  input  1  CPU address bit A0, valid with wr_stb
int_data  input  8  internal data bus byte, valid with wr_stb
init_done  output  1  ICW sequence complete
icw1_pulse  output  1  one-cycle pulse on any ICW1 (clears ISR/priority downstream)
ltim  output  1  ICW1 D3, level-triggered mode
sngl  output  1  ICW1 D1, single (no cascade)
ic4  output  1  ICW1 D0, ICW4 needed
vector_base  output  5  ICW2 D7..D3
cascade_cfg  output  8  ICW3 byte
upm  output  1  ICW4 D0
aeoi  output  1  ICW4 D1
ms_sel  output  1  ICW4 D2
buf_mode  output  1  ICW4 D3
sfnm  output  1  ICW4 D4
imr  output  8  interrupt mask (OCW1)
ocw2_valid  output  1  one-cycle pulse on OCW2 write
ocw2_cmd  output  3  OCW2 D7..D5 (R, SL, EOI)
ocw2_level  output  3  OCW2 D2..D0
read_isr  output  1  OCW3 RIS, status read select
poll_pulse  output  1  one-cycle pulse, OCW3 P=1
smm  output  1  special mask mode
fsm_state  output  3  current state encoding, for debug/verification

Behaviour:
- Reset (async) values:
  - State WAIT_ICW1; init_done=0; imr=IMR_INIT; vector_base=VECTOR_INIT.
  - All other outputs 0; all pulses 0.
- Writes are acted on only in a clk cycle with wr_stb=1. Register and state updates are visible on the cycle after the strobe edge.
- Pulses are high for exactly that one following cycle.
- Back-to-back strobes on consecutive cycles are each decoded fully.
- Decode:
  - ICW1 = a0=0 & D4=1, accepted in ANY state; it has priority over all other decodes.
  - OCW2 = a0=0 & D4=0 & D3=0.
  - OCW3 = a0=0 & D4=0 & D3=1.
  - a0=1 means ICW2/3/4 during init, and OCW1 in READY.
- FSM states: WAIT_ICW1=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4.
- ICW1 (any state):
  - Latch ltim, sngl, ic4.
  - imr<=IMR_INIT; init_done<=0; read_isr<=0; smm<=0.
  - If ic4=0, clear upm, aeoi, ms_sel, buf_mode, sfnm.
  - Pulse icw1_pulse; go to WAIT_ICW2.
- WAIT_ICW2, a0=1: latch vector_base=D7..D3. Next state is WAIT_ICW3 if sngl=0; else WAIT_ICW4 if ic4=1; else READY.
- WAIT_ICW3, a0=1: latch cascade_cfg. Next state is WAIT_ICW4 if ic4=1, else READY.
- WAIT_ICW4, a0=1: latch upm, aeoi, ms_sel, buf_mode, sfnm; go to READY.
- On entry to READY, init_done<=1 in the same update.
- Writes that are not accepted in a state produce no state change and no pulse:
  - a0=0 non-ICW1 writes in WAIT_ICW1..WAIT_ICW4.
  - a0=1 writes in WAIT_ICW1.
- READY:
  - a0=1: imr<=int_data.
  - OCW2: pulse ocw2_valid; ocw2_cmd/ocw2_level latched and held until the next OCW2.
  - OCW3: if RR (D1)=1 then read_isr<=RIS (D0), else read_isr unchanged. If P (D2)=1, pulse poll_pulse.
- ICW1 in the middle of the init sequence restarts it; previously latched ICW2/ICW3 values are held until overwritten.
- Reset asserted mid-sequence returns all state to reset values immediately, regardless of clk.

Optional Feature:
PIC_SPECIAL_MASK_EN:
- Defined: OCW3 with ESMM (D6)=1 sets smm<=SMM (D5); ESMM=0 leaves smm unchanged.
- Undefined: smm tied to 0; D6/D5 ignored; no smm flop synthesized.

Decomposition:
- Shared package pic_pkg holds:
  - State enum.
  - ICW/OCW bit-position constants (D4_ICW1, D3_OCW3, RR, RIS, P, ESMM, SMM).
  - OCW2 command codes (NS_EOI=3'b001, SP_EOI=3'b011, ROT_NS_EOI=3'b101, SET_PRIO=3'b110, etc.).
- Single module, no sub-module; decode is a small combinational block alongside the FSM.

Test Plan:
1. Reset -> fsm_state=0, init_done=0, imr=8'h00, all pulses 0. a0=1 write of 8'hFF before ICW1 -> imr remains 8'h00.
2. Writes 11h(a0=0), 20h, 04h, 01h (a0=1) -> icw1_pulse once; vector_base=5'b00100, cascade_cfg=8'h04, upm=1; states 1,2,3,4; init_done=1 one cycle after 4th strobe.
3. Writes 13h then 08h -> ICW3 skipped, state WAIT_ICW4. Writes 12h then 40h -> READY after ICW2; upm/aeoi=0.
4. In READY: a0=1 A5h -> imr=A5h. 20h (a0=0) -> ocw2_valid one cycle, ocw2_cmd=3'b001, level=0. 0Bh -> read_isr=1. 0Ch -> poll_pulse one cycle.
5. After ICW2, write 11h -> state back to WAIT_ICW2, imr reset, init_done=0. Assert reset between strobes -> outputs return to reset values asynchronously.
6. With PIC_SPECIAL_MASK_EN defined: 68h -> smm=1, 48h -> smm=0. Undefined: smm stays 0.
